// File: rtl/alu_seq.sv
// alu_seq: clocked, multi-cycle ALU with registered result and flags.
//
// Single-cycle ops finish two cycles after the accepting edge; LSL/LSR shift one
// bit per cycle and MUL runs one shift-add step per cycle. A start is accepted only
// in IDLE; busy is high while working and done pulses for one cycle when result,
// result_hi and flags become valid.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      synchronous, active-high reset
//   start      request, sampled only in IDLE
//   op         opcode, captured with start
//   arg_0      operand A, captured with start
//   arg_1      operand B (shift amount for LSL/LSR), captured with start
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle completion pulse
//   result     registered low result
//   result_hi  upper product half for MUL, 0 otherwise
//   flags      {CARRY, ZERO, EQUAL, PARITY, BEVEN}
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] arg_0,
    input  logic [WIDTH-1:0] arg_1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpLsl = 4'd1;
    localparam logic [3:0] OpXor = 4'd2;
    localparam logic [3:0] OpAnd = 4'd3;
    localparam logic [3:0] OpCmp = 4'd4;
    localparam logic [3:0] OpSet = 4'd5;
    localparam logic [3:0] OpLsr = 4'd6;
    localparam logic [3:0] OpSub = 4'd7;
    localparam logic [3:0] OpAdc = 4'd8;
    localparam logic [3:0] OpMul = 4'd9;

    typedef enum logic [2:0] {StIdle, StExec, StShift, StMul, StDone} state_e;

    state_e           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] work_lo;   // shift register, or multiplier / low product half
    logic [WIDTH-1:0] work_hi;   // partial-product accumulator for MUL

    // Single-cycle datapath
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   adc_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] exec_res;
    logic             exec_carry;

    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign adc_full = add_full + {{WIDTH{1'b0}}, flags[4]};
    assign sub_full = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        exec_res   = '0;
        exec_carry = 1'b0;
        case (op_q)
            OpAdd: begin exec_res = add_full[WIDTH-1:0]; exec_carry = add_full[WIDTH]; end
            OpAdc: begin exec_res = adc_full[WIDTH-1:0]; exec_carry = adc_full[WIDTH]; end
            OpSub: begin exec_res = sub_full[WIDTH-1:0]; exec_carry = sub_full[WIDTH]; end
            OpXor: exec_res = a_q ^ b_q;
            OpAnd: exec_res = a_q & b_q;
            OpSet: exec_res = b_q;
            OpCmp: exec_carry = (a_q < b_q);
            default: ;
        endcase
    end

    // Shifts with s==0 or s>=WIDTH finish without entering the shift loop
    logic             is_shift;
    logic             is_lsl;
    logic             is_nop;
    logic [31:0]      s_ext;
    logic             shift_trivial;
    logic [WIDTH-1:0] triv_res;
    logic             triv_carry;

    assign is_lsl   = (op_q == OpLsl);
    assign is_shift = is_lsl || (op_q == OpLsr);
    assign is_nop   = (op_q >= 4'd10);
    assign s_ext    = 32'(b_q);
    assign shift_trivial = (s_ext == 32'd0) || (s_ext >= WIDTH);

    always_comb begin
        triv_res   = '0;
        triv_carry = 1'b0;
        if (s_ext == 32'd0) begin
            triv_res = a_q;
        end else if (s_ext == WIDTH) begin
            triv_carry = is_lsl ? a_q[0] : a_q[WIDTH-1];
        end
    end

    // One shift step; carry is the bit leaving the register
    logic [WIDTH-1:0] shift_next;
    logic             shift_out;

    assign shift_next = is_lsl ? {work_lo[WIDTH-2:0], 1'b0} : {1'b0, work_lo[WIDTH-1:1]};
    assign shift_out  = is_lsl ? work_lo[WIDTH-1] : work_lo[0];

    // One shift-add step: add A into the high half when the multiplier LSB is set,
    // then shift {carry, hi, lo} right; after WIDTH steps {hi, lo} is the product.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, work_lo[WIDTH-1:1]};

    // Completion decode: fin marks the edge that raises done
    logic             fin;
    logic             fin_flags;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH-1:0] fin_hi;
    logic             fin_carry;

    always_comb begin
        fin       = 1'b0;
        fin_flags = 1'b0;
        fin_res   = result;
        fin_hi    = '0;
        fin_carry = 1'b0;
        case (state)
            StExec: begin
                if (is_shift) begin
                    if (shift_trivial) begin
                        fin       = 1'b1;
                        fin_flags = 1'b1;
                        fin_res   = triv_res;
                        fin_carry = triv_carry;
                    end
                end else if (op_q == OpMul) begin
                    fin = 1'b0;
                end else if (is_nop) begin
                    // NOP completes but leaves result, result_hi and flags untouched
                    fin    = 1'b1;
                    fin_hi = result_hi;
                end else begin
                    fin       = 1'b1;
                    fin_flags = 1'b1;
                    fin_res   = exec_res;
                    fin_carry = exec_carry;
                end
            end
            StShift: begin
                if (cnt == SHW'(1)) begin
                    fin       = 1'b1;
                    fin_flags = 1'b1;
                    fin_res   = shift_next;
                    fin_carry = shift_out;
                end
            end
            StMul: begin
                if (cnt == SHW'(1)) begin
                    fin       = 1'b1;
                    fin_flags = 1'b1;
                    fin_res   = mul_next[WIDTH-1:0];
                    fin_hi    = mul_next[2*WIDTH-1:WIDTH];
                    fin_carry = (mul_next[2*WIDTH-1:WIDTH] != '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            work_lo   <= '0;
            work_hi   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= arg_0;
                        b_q   <= arg_1;
                        busy  <= 1'b1;
                        state <= StExec;
                    end
                end
                StExec: begin
                    if (op_q == OpMul) begin
                        work_hi <= '0;
                        work_lo <= b_q;
                        cnt     <= SHW'(WIDTH);
                        state   <= StMul;
                    end else if (is_shift && !shift_trivial) begin
                        work_lo <= a_q;
                        cnt     <= SHW'(b_q);
                        state   <= StShift;
                    end
                end
                StShift: begin
                    work_lo <= shift_next;
                    cnt     <= cnt - SHW'(1);
                end
                StMul: begin
                    work_hi <= mul_next[2*WIDTH-1:WIDTH];
                    work_lo <= mul_next[WIDTH-1:0];
                    cnt     <= cnt - SHW'(1);
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase

            if (fin) begin
                state     <= StDone;
                busy      <= 1'b0;
                done      <= 1'b1;
                result    <= fin_res;
                result_hi <= fin_hi;
                if (fin_flags) begin
                    flags <= {fin_carry, (fin_res == '0), (a_q == b_q), ^a_q, ~fin_res[0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed expectations for alu_seq (WIDTH=8).
// Flags are {CARRY, ZERO, EQUAL, PARITY, BEVEN}.
module tb_alu_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [3:0] op;
    logic [7:0] arg_0;
    logic [7:0] arg_1;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [4:0] flags;

    int n_total = 0;
    int n_bad   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .op        (op),
        .arg_0     (arg_0),
        .arg_1     (arg_1),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                             input logic [4:0] fl);
        check({tag, "_res"}, 32'(result), 32'(res));
        check({tag, "_hi"}, 32'(result_hi), 32'(hi));
        check({tag, "_flags"}, 32'(flags), 32'(fl));
    endtask

    // Issue one op and wait for done; inputs are scrambled while busy to show they are ignored.
    task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_cycles);
        @(negedge Clk);
        start = 1'b1;
        op    = o;
        arg_0 = a;
        arg_1 = b;
        @(posedge Clk);
        #1;
        start = 1'b0;
        op    = ~o;
        arg_0 = ~a;
        arg_1 = ~b;
        lat         = -1;
        busy_cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                         input logic [7:0] b, input int exp_lat);
        int lat;
        int bc;
        run_op(o, a, b, lat, bc);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bc), 32'(exp_lat - 1));
    endtask

    initial begin
        int lat;
        int dones;

        Reset = 1'b1;
        start = 1'b0;
        op    = '0;
        arg_0 = '0;
        arg_1 = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_out("rst", 8'h00, 8'h00, 5'h00);
        Reset = 1'b0;

        // ADD FF+01: wraps to 0 with carry
        do_op("add", 4'd0, 8'hFF, 8'h01, 2);
        check_out("add", 8'h00, 8'h00, 5'b11001);

        // ADC consumes the carry from ADD
        do_op("adc", 4'd8, 8'h10, 8'h20, 2);
        check_out("adc", 8'h31, 8'h00, 5'b00010);

        // LSL 0x81 by 3: last bit out is bit 5
        do_op("lsl3", 4'd1, 8'h81, 8'd3, 5);
        check_out("lsl3", 8'h08, 8'h00, 5'b00001);

        do_op("lsl1", 4'd1, 8'h81, 8'd1, 3);
        check_out("lsl1", 8'h02, 8'h00, 5'b10001);

        // Oversized shift completes immediately
        do_op("lsr9", 4'd6, 8'h81, 8'd9, 2);
        check_out("lsr9", 8'h00, 8'h00, 5'b01001);

        // LSR by exactly WIDTH: carry is arg_0 MSB
        do_op("lsr8", 4'd6, 8'h81, 8'd8, 2);
        check_out("lsr8", 8'h00, 8'h00, 5'b11001);

        // LSR 0x81 by 2: last bit out is bit 1
        do_op("lsr2", 4'd6, 8'h81, 8'd2, 4);
        check_out("lsr2", 8'h20, 8'h00, 5'b00001);

        // MUL FF*FF = FE01, with a stray start while busy
        @(negedge Clk);
        start = 1'b1;
        op    = 4'd9;
        arg_0 = 8'hFF;
        arg_1 = 8'hFF;
        @(posedge Clk);
        #1;
        start = 1'b0;
        lat   = -1;
        dones = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge Clk);
            if (c == 3) begin
                start = 1'b1;
                op    = 4'd0;
                arg_0 = 8'h01;
                arg_1 = 8'h01;
            end
            if (c == 6) start = 1'b0;
            if (done) begin
                dones++;
                if (lat < 0) lat = c;
            end
        end
        check("mul_lat", 32'(lat), 32'd10);
        check("mul_dones", 32'(dones), 32'd1);
        check_out("mul", 8'h01, 8'hFE, 5'b10100);

        // CMP 05 vs 07
        do_op("cmp", 4'd4, 8'h05, 8'h07, 2);
        check_out("cmp", 8'h00, 8'h00, 5'b11001);

        // NOP: operands would change EQUAL/PARITY if flags were written
        do_op("nop", 4'd12, 8'h01, 8'h01, 2);
        check_out("nop", 8'h00, 8'h00, 5'b11001);

        // SET and XOR clear carry
        do_op("set", 4'd5, 8'h3C, 8'hA5, 2);
        check_out("set", 8'hA5, 8'h00, 5'b00000);
        do_op("xor", 4'd2, 8'h0F, 8'h0F, 2);
        check_out("xor", 8'h00, 8'h00, 5'b01101);

        // Reset in the middle of a MUL
        @(negedge Clk);
        start = 1'b1;
        op    = 4'd9;
        arg_0 = 8'h12;
        arg_1 = 8'h34;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check_out("mrst", 8'h00, 8'h00, 5'h00);
        Reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge Clk);
            if (done) dones++;
        end
        check("mrst_no_done", 32'(dones), 32'd0);

        // Fresh SUB after reset: borrow
        do_op("sub", 4'd7, 8'h03, 8'h05, 2);
        check_out("sub", 8'hFE, 8'h00, 5'b10001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor of the combinational datapath ALU.
- Operands are WIDTH bits wide, and results and flags are registered.
- Shifts and multiply are multi-cycle, sequenced by a start/busy/done handshake.
- A persistent flag register feeds carry into ADC. The block sits between the register file and the writeback mux, and control stalls fetch while busy is high.

Parameters:
- WIDTH, 8, operand/result width; legal range 4..32.
- SHW, $clog2(WIDTH)+1, width of the internal shift-count register.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  4  opcode, captured with start.
- arg_0  input  WIDTH  operand A, captured with start.
- arg_1  input  WIDTH  operand B, or shift amount for LSL/LSR, captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  registered low result; held until the next done.
- result_hi  output  WIDTH  upper product half for MUL; 0 for all other ops.
- flags  output  5  registered {CARRY, ZERO, EQUAL, PARITY, BEVEN}; held between updates.

Behaviour:
- Reset (synchronous, active-high, highest priority, also mid-operation):
  - state=IDLE; busy=0, done=0, result=0, result_hi=0, flags=0.
  - Any in-flight operation is discarded.
- Operand capture:
  - A start seen in IDLE at edge N latches op, arg_0 and arg_1.
  - A start while busy=1 or done=1 is ignored (not queued).
- Opcodes:
  - 0 ADD; 1 LSL; 2 XOR; 3 AND; 4 CMP; 5 SET (result=arg_1).
  - 6 LSR; 7 SUB; 8 ADC (arg_0+arg_1+CARRY flag); 9 MUL (unsigned).
  - 10-15 NOP.
- State machine: IDLE -> EXEC (single-cycle ops) | SHIFT | MUL -> DONE -> IDLE.
  - DONE lasts one cycle and asserts done=1, busy=0.
  - A new start may be sampled in the cycle after DONE.
- Latency, counted as cycles from edge N to done=1:
  - Single-cycle ops, NOP and CMP: 2.
  - LSL/LSR with s=arg_1: 2 if s==0 or s>=WIDTH; otherwise s+2, shifting one bit per cycle.
  - MUL: WIDTH+2, using one shift-add step per cycle.
- Arithmetic and width:
  - All ops are modulo 2^WIDTH.
  - For ADD/ADC, CARRY = carry out of bit WIDTH-1.
  - For SUB, CARRY = borrow (arg_0 < arg_1 unsigned).
  - For LSL, CARRY = last bit shifted out of bit WIDTH-1; for LSR, CARRY = last bit shifted out of bit 0. For s==0, CARRY=0.
  - For s>=WIDTH: result=0, and CARRY = arg_0[0] for LSL with s==WIDTH, else 0; the LSR mirror is arg_0[WIDTH-1].
  - MUL gives {result_hi, result} = arg_0*arg_arg_1 in full 2*WIDTH bits; CARRY = (result_hi != 0).
- Flags (updated at the edge that raises done; never updated by NOP):
  - ZERO = (result==0).
  - BEVEN = ~result[0].
  - PARITY = ^arg_0, using the captured operand.
  - EQUAL = (arg_0==arg_1), using the captured operands.
  - CMP writes result=0 and sets CARRY = (arg_0<arg_1) and EQUAL; ZERO=1 and BEVEN=1 follow from result=0.
  - XOR, AND and SET clear CARRY.
- Output stability:
  - result and result_hi change only at the done edge or at reset.
  - Input changes while busy have no effect.

Test Plan:
- Reset, then ADD with WIDTH=8, arg_0=0xFF, arg_1=0x01 -> done 2 cycles after start; result=0x00, CARRY=1, ZERO=1, BEVEN=1, PARITY=0, EQUAL=0.
- ADC immediately after the previous ADD, arg_0=0x10, arg_1=0x20 -> result=0x31 (CARRY-in used), CARRY=0.
- LSL arg_0=0x81, arg_1=3 -> done exactly 5 cycles after start, busy high for cycles 1-4; result=0x08, CARRY=0 (last bit out = bit 5 of 0x81).
  - LSL arg_0=0x81, arg_1=1 -> result=0x02, CARRY=1.
  - LSR arg_0=0x81, arg_1=9 -> latency 2, result=0, CARRY=0.
- MUL arg_0=0xFF, arg_1=0xFF -> done 10 cycles after start; result_hi=0xFE, result=0x01, CARRY=1; a second start while busy is ignored (exactly one done pulse).
- CMP arg_0=0x05, arg_1=0x07 -> result=0, CARRY=1, EQUAL=0, ZERO=1; NOP (op=12) afterwards -> done at 2, flags unchanged.
- Start MUL, assert Reset at cycle 4 -> next cycle busy=0, done=0, result=0, flags=0; no late done pulse; a fresh SUB 0x03-0x05 gives 0xFE with CARRY=1.
